// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: two source FIFOs feeding a registered DAC code,
// round-robin arbitrated on each PWM window strobe.
// Optional build macro DAC_SCHED_UNDERFLOW_CNT_EN enables the underflow
// window counter; without it underflow_cnt is tied to zero.
module dac_sample_scheduler #(
  parameter int CODE_WIDTH = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CODE_WIDTH-1:0] s0_code,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [CODE_WIDTH-1:0] s1_code,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic                  next_sample,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  active_src,
  output logic                  running,
  output logic [15:0]           underflow_cnt
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PRIME_CNT = CW'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic                  act_q, act_d;
  logic                  last_q, last_d;

  logic [CODE_WIDTH-1:0] mem_q [2][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q [2];
  logic [AW-1:0]         rd_ptr_q [2];
  logic [CW-1:0]         cnt_q [2];

  logic [CODE_WIDTH-1:0] in_code [2];
  logic [1:0]            in_valid, ready, push, pop;
  logic                  flush, underflow, do_pop, grant;

  assign in_code[0] = s0_code;
  assign in_code[1] = s1_code;
  assign in_valid   = {s1_valid, s0_valid};

  // Ready only reflects pre-edge occupancy; a same-cycle pop does not open a slot.
  assign ready[0] = (state_q != IDLE) && (cnt_q[0] != FULL_CNT);
  assign ready[1] = (state_q != IDLE) && (cnt_q[1] != FULL_CNT);
  assign push     = in_valid & ready;

  assign s0_ready   = ready[0];
  assign s1_ready   = ready[1];
  assign code       = code_q;
  assign active_src = act_q;
  assign running    = (state_q == RUN);

  // Next-state, flush and round-robin pop selection.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    act_d     = act_q;
    last_d    = last_q;
    pop       = '0;
    flush     = 1'b0;
    underflow = 1'b0;
    do_pop    = 1'b0;
    grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = PRIME;
      end
      PRIME: begin
        if (!en) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (next_sample && (cnt_q[0] >= PRIME_CNT || cnt_q[1] >= PRIME_CNT)) begin
          state_d = RUN;
          do_pop  = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (next_sample) begin
          do_pop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      code_d = '0;
      act_d  = 1'b0;
    end
    if (do_pop) begin
      if (cnt_q[0] != '0 && cnt_q[1] != '0) grant = ~last_q;
      else if (cnt_q[0] != '0)              grant = 1'b0;
      else if (cnt_q[1] != '0)              grant = 1'b1;
      else                                  underflow = 1'b1;
      if (!underflow) begin
        pop[grant] = 1'b1;
        code_d     = mem_q[grant][rd_ptr_q[grant]];
        act_d      = grant;
        last_d     = grant;
      end
    end
  end

  // Control state, output code and FIFO pointers/counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      act_q   <= 1'b0;
      last_q  <= 1'b1;
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      act_q   <= act_d;
      last_q  <= last_d;
      for (int s = 0; s < 2; s++) begin
        if (flush) begin
          wr_ptr_q[s] <= '0;
          rd_ptr_q[s] <= '0;
          cnt_q[s]    <= '0;
        end else begin
          if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + 1'b1;
          if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
          cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        end
      end
    end
  end

  // Sample storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s]] <= in_code[s];
    end
  end

`ifdef DAC_SCHED_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q;

  // Saturating count of strobed windows that found both FIFOs empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else if (underflow && ucnt_q != 16'hFFFF) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underflow_cnt = ucnt_q;
`else
  logic unused_underflow;
  assign unused_underflow = underflow;
  assign underflow_cnt    = '0;
`endif

endmodule
